// File: rtl/cc_alu_seq_pkg.sv
// cc_alu_seq_pkg: opcodes, FSM state encoding and CC-opcode test shared by the sequential ALU
package cc_alu_seq_pkg;
  localparam logic [3:0] OP_ANDCC  = 4'd0;
  localparam logic [3:0] OP_ORCC   = 4'd1;
  localparam logic [3:0] OP_NORCC  = 4'd2;
  localparam logic [3:0] OP_ADDCC  = 4'd3;
  localparam logic [3:0] OP_SUBCC  = 4'd4;
  localparam logic [3:0] OP_AND    = 4'd5;
  localparam logic [3:0] OP_OR     = 4'd6;
  localparam logic [3:0] OP_NOR    = 4'd7;
  localparam logic [3:0] OP_ADD    = 4'd8;
  localparam logic [3:0] OP_SUB    = 4'd9;
  localparam logic [3:0] OP_SLL    = 4'd10;
  localparam logic [3:0] OP_SRL    = 4'd11;
  localparam logic [3:0] OP_SRA    = 4'd12;
  localparam logic [3:0] OP_SEXT13 = 4'd13;
  localparam logic [3:0] OP_INCPC  = 4'd14;
  localparam logic [3:0] OP_PASSA  = 4'd15;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
  function automatic logic is_cc(input logic [3:0] op);
    return op <= OP_SUBCC;
  endfunction
endpackage

// File: rtl/cc_alu_seq_core.sv
// cc_alu_seq_core: combinational single-cycle result and next N/Z/V/C flags (shift ops pass A through)
module cc_alu_seq_core
  import cc_alu_seq_pkg::*;
#(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DATAWIDTH_ALU_SELECTION = 4
) (
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] opcode,
  input  logic [DATAWIDTH_BUS-1:0]           dataA,
  input  logic [DATAWIDTH_BUS-1:0]           dataB,
  output logic [DATAWIDTH_BUS-1:0]           result,
  output logic [3:0]                         flags
);
  localparam int W = DATAWIDTH_BUS;
  logic [W:0] sum, diff;
  logic addV, subV;
  always_comb begin
    sum = {1'b0, dataA} + {1'b0, dataB};
    diff = {1'b0, dataA} - {1'b0, dataB};
    case (opcode)
      OP_ANDCC, OP_AND: result = dataA & dataB;
      OP_ORCC, OP_OR:   result = dataA | dataB;
      OP_NORCC, OP_NOR: result = ~(dataA | dataB);
      OP_ADDCC, OP_ADD: result = sum[W-1:0];
      OP_SUBCC, OP_SUB: result = diff[W-1:0];
      OP_SEXT13:        result = {{(W-13){dataA[12]}}, dataA[12:0]};
      OP_INCPC:         result = dataA + W'(4);
      default:          result = dataA;
    endcase
    addV = (dataA[W-1] == dataB[W-1]) && (result[W-1] != dataA[W-1]);
    subV = (dataA[W-1] != dataB[W-1]) && (result[W-1] != dataA[W-1]);
    flags = {result[W-1], result == '0,
             opcode == OP_ADDCC ? addV : opcode == OP_SUBCC ? subV : 1'b0,
             opcode == OP_ADDCC ? sum[W] : opcode == OP_SUBCC ? diff[W] : 1'b0};
  end
endmodule

// File: rtl/cc_alu_seq.sv
// cc_alu_seq: registered ALU with start/ready/done handshake, iterative 1-bit/cycle shifts and active-low CC flags
module cc_alu_seq
  import cc_alu_seq_pkg::*;
#(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int DATAWIDTH_SHAMT = $clog2(DATAWIDTH_BUS)
) (
  input  logic                               CC_ALUSEQ_CLOCK_50,
  input  logic                               CC_ALUSEQ_RESET_InHigh,
  input  logic                               CC_ALUSEQ_start_In,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUSEQ_selection_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_dataA_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_dataB_InBUS,
  output logic                               CC_ALUSEQ_ready_Out,
  output logic                               CC_ALUSEQ_done_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_data_OutBUS,
  output logic                               CC_ALUSEQ_negative_OutLow,
  output logic                               CC_ALUSEQ_zero_OutLow,
  output logic                               CC_ALUSEQ_overflow_OutLow,
  output logic                               CC_ALUSEQ_carry_OutLow
);
  localparam int W = DATAWIDTH_BUS;
  localparam int SH = DATAWIDTH_SHAMT;
  state_t state;
  logic [W-1:0] shReg, stepped, coreResult, dataOut;
  logic [SH-1:0] count, shAmt;
  logic [DATAWIDTH_ALU_SELECTION-1:0] opReg, sel;
  logic [3:0] flags, coreFlags;
  logic accept, isShift;
  assign sel = CC_ALUSEQ_selection_InBUS;
  assign shAmt = CC_ALUSEQ_dataB_InBUS[SH-1:0];
  assign CC_ALUSEQ_ready_Out = state != ST_SHIFT;
  assign CC_ALUSEQ_done_Out = state == ST_DONE;
  assign accept = CC_ALUSEQ_start_In && CC_ALUSEQ_ready_Out;
  assign isShift = sel == OP_SLL || sel == OP_SRL || sel == OP_SRA;
  assign stepped = opReg == OP_SLL ? shReg << 1 : {opReg == OP_SRA && shReg[W-1], shReg[W-1:1]};
  assign CC_ALUSEQ_data_OutBUS = dataOut;
  assign CC_ALUSEQ_negative_OutLow = ~flags[3];
  assign CC_ALUSEQ_zero_OutLow = ~flags[2];
  assign CC_ALUSEQ_overflow_OutLow = ~flags[1];
  assign CC_ALUSEQ_carry_OutLow = ~flags[0];
  cc_alu_seq_core #(
    .DATAWIDTH_BUS(DATAWIDTH_BUS),
    .DATAWIDTH_ALU_SELECTION(DATAWIDTH_ALU_SELECTION)
  ) core (
    .opcode(sel),
    .dataA(CC_ALUSEQ_dataA_InBUS),
    .dataB(CC_ALUSEQ_dataB_InBUS),
    .result(coreResult),
    .flags(coreFlags)
  );
  always_ff @(posedge CC_ALUSEQ_CLOCK_50) begin
    if (CC_ALUSEQ_RESET_InHigh) begin
      state <= ST_IDLE;
      dataOut <= '0;
      flags <= '0;
      shReg <= '0;
      count <= '0;
      opReg <= '0;
    end else if (accept) begin
      opReg <= sel;
      shReg <= CC_ALUSEQ_dataA_InBUS;
      count <= shAmt;
      if (isShift && shAmt != '0) state <= ST_SHIFT;
      else begin
        state <= ST_DONE;
        dataOut <= coreResult;
        if (is_cc(sel)) flags <= coreFlags;
      end
    end else if (state == ST_SHIFT) begin
      shReg <= stepped;
      count <= count - SH'(1);
      if (count == SH'(1)) begin
        state <= ST_DONE;
        dataOut <= stepped;
      end
    end else if (state == ST_DONE) state <= ST_IDLE;
  end
endmodule
